// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 32-bit datapath control sequencer: sizing
// constants, opcode values, instruction-register field positions, the FSM
// state encoding, the op-class enum, the bundled datapath strobes and small
// register-select helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int NUM_REGS    = 16;
   localparam int REG_IDX_W   = 4;
   localparam int OPCODE_W    = 5;
   localparam int MEM_TIMEOUT = 15;

   // Instruction register field positions
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   // Opcodes
   localparam logic [OPCODE_W-1:0] OP_ADD = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_SUB = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_AND = 5'b00101;
   localparam logic [OPCODE_W-1:0] OP_OR  = 5'b00110;
   localparam logic [OPCODE_W-1:0] OP_MUL = 5'b01111;
   localparam logic [OPCODE_W-1:0] OP_DIV = 5'b10000;
   localparam logic [OPCODE_W-1:0] OP_NEG = 5'b10001;
   localparam logic [OPCODE_W-1:0] OP_NOT = 5'b10010;

   // Sequencer state encoding
   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_FETCH0 = 4'd1;
   localparam logic [3:0] ST_FETCH1 = 4'd2;
   localparam logic [3:0] ST_FETCH2 = 4'd3;
   localparam logic [3:0] ST_DECODE = 4'd4;
   localparam logic [3:0] ST_T3     = 4'd5;
   localparam logic [3:0] ST_T4     = 4'd6;
   localparam logic [3:0] ST_T5     = 4'd7;
   localparam logic [3:0] ST_T6     = 4'd8;
   localparam logic [3:0] ST_HALT   = 4'd9;

   typedef enum logic [1:0] {
      BINARY  = 2'd0,
      UNARY   = 2'd1,
      MULDIV  = 2'd2,
      ILLEGAL = 2'd3
   } op_class_t;

   // Single-bit datapath strobes, MSB first in port-list order
   typedef struct packed {
      logic pcout;
      logic pcin;
      logic marin;
      logic mdrin;
      logic mdrout;
      logic irin;
      logic yin;
      logic zin;
      logic zhighout;
      logic zlowout;
      logic hiin;
      logic loin;
      logic read;
      logic incpc;
   } strobes_t;

   // True when a register field addresses an implemented register.
   function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
      if (NUM_REGS >= (32'sd1 <<< REG_IDX_W)) begin
         idx_ok = 1'b1;
      end else begin
         idx_ok = (32'(idx) < 32'(NUM_REGS));
      end
   endfunction

   // One-hot register select from a register field.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
      reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/ctrl_sequencer_chk.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer_chk
// Simulation-only property checker for ctrl_sequencer outputs.
// Ports:
//   clk, rst                         sequencer clock and active-high reset
//   rin, rout                        register load / drive selects
//   pcout, mdrout, zhighout, zlowout remaining bus drivers
// -----------------------------------------------------------------------------
module ctrl_sequencer_chk
   import cpu_pkg::*;
(
   input logic                clk,
   input logic                rst,
   input logic [NUM_REGS-1:0] rin,
   input logic [NUM_REGS-1:0] rout,
   input logic                pcout,
   input logic                mdrout,
   input logic                zhighout,
   input logic                zlowout
);

   // Falling-edge sampling: registered strobes are settled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         a_one_driver: assert ($countones({rout, pcout, mdrout, zhighout, zlowout}) <= 32'sd1)
            else $error("ctrl_sequencer_chk: more than one bus driver active");
         a_one_load: assert ($countones(rin) <= 32'sd1)
            else $error("ctrl_sequencer_chk: more than one register load enable");
      end
   end

endmodule

// File: rtl/ctrl_sequencer_op_classifier.sv
// -----------------------------------------------------------------------------
// op_classifier
// Combinational opcode-to-class decode for the control sequencer.
// Ports:
//   opcode   in   OPCODE_W   opcode field of the instruction register
//   op_class out  op_class_t BINARY / UNARY / MULDIV / ILLEGAL
// -----------------------------------------------------------------------------
module op_classifier
   import cpu_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output op_class_t           op_class
);

   // Map each known opcode to the execute sequence it needs
   always_comb begin
      op_class = ILLEGAL;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = BINARY;
         OP_MUL, OP_DIV:                op_class = MULDIV;
         OP_NEG, OP_NOT:                op_class = UNARY;
         default:                       op_class = ILLEGAL;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
// Hardware control sequencer for the 32-bit datapath. Fetches an instruction
// (with a bounded memory wait), decodes opcode/Ra/Rb/Rc and drives one-hot
// control strobes through the execute steps of binary, unary and HI/LO
// (mul/div) operations. Illegal opcodes and memory timeouts set sticky faults.
// Every output is a flop computed from the next state (Moore, registered).
// Ports:
//   Clock      in   system clock, rising edge
//   clear      in   asynchronous active-high reset
//   run        in   1 = keep sequencing instructions
//   mem_ready  in   memory data valid for the current Read
//   IR         in   instruction register contents
//   Rin/Rout   out  one-hot register load enables / bus drivers
//   PCout..IncPC out single-bit datapath strobes
//   alu_op     out  ALU operation, valid while Zin=1
//   busy       out  sequencer not idle
//   done       out  one-cycle pulse on the final step of an instruction
//   fault      out  sticky: bit0 illegal instruction, bit1 memory timeout
// -----------------------------------------------------------------------------
module ctrl_sequencer
   import cpu_pkg::*;
(
   input  logic                Clock,
   input  logic                clear,
   input  logic                run,
   input  logic                mem_ready,
   input  logic [31:0]         IR,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                PCout,
   output logic                PCin,
   output logic                MARin,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                Zhighout,
   output logic                Zlowout,
   output logic                HIin,
   output logic                LOin,
   output logic                Read,
   output logic                IncPC,
   output logic [OPCODE_W-1:0] alu_op,
   output logic                busy,
   output logic                done,
   output logic [1:0]          fault
);

   localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

   logic [3:0]           state_q, state_d;
   logic [3:0]           wait_cnt_q, wait_cnt_d;
   logic [1:0]           fault_q, fault_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   strobes_t             stb_q, stb_d;
   logic [NUM_REGS-1:0]  rin_q, rin_d;
   logic [NUM_REGS-1:0]  rout_q, rout_d;
   logic [OPCODE_W-1:0]  alu_q, alu_d;

   // Instruction fields captured in DECODE for the execute steps
   logic [OPCODE_W-1:0]  op_q, op_d;
   logic [REG_IDX_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   op_class_t            cls_q, cls_d;

   logic [OPCODE_W-1:0]  ir_op_s;
   logic [REG_IDX_W-1:0] ir_ra_s, ir_rb_s, ir_rc_s;
   op_class_t            raw_cls_s, ir_cls_s;
   logic [OPCODE_W-1:0]  sel_op_s;
   logic [REG_IDX_W-1:0] sel_ra_s, sel_rb_s, sel_rc_s;
   op_class_t            sel_cls_s;
   logic                 illegal_trap_s;
   logic [3:0]           next_instr_s;
   logic                 unused_ir_s;

   assign ir_op_s     = IR[OP_MSB:OP_LSB];
   assign ir_ra_s     = IR[RA_MSB:RA_LSB];
   assign ir_rb_s     = IR[RB_MSB:RB_LSB];
   assign ir_rc_s     = IR[RC_MSB:RC_LSB];
   assign unused_ir_s = ^IR[RC_LSB-1:0];

   op_classifier u_op_classifier (
      .opcode   (ir_op_s),
      .op_class (raw_cls_s)
   );

   // Fold out-of-range register fields into the illegal class
   always_comb begin
      ir_cls_s = raw_cls_s;
      case (raw_cls_s)
         BINARY: begin
            if (!(idx_ok(ir_ra_s) && idx_ok(ir_rb_s) && idx_ok(ir_rc_s))) ir_cls_s = ILLEGAL;
            else ir_cls_s = BINARY;
         end
         UNARY: begin
            if (!(idx_ok(ir_ra_s) && idx_ok(ir_rb_s))) ir_cls_s = ILLEGAL;
            else ir_cls_s = UNARY;
         end
         MULDIV: begin
            if (!(idx_ok(ir_rb_s) && idx_ok(ir_rc_s))) ir_cls_s = ILLEGAL;
            else ir_cls_s = MULDIV;
         end
         default: ir_cls_s = ILLEGAL;
      endcase
   end

   // In DECODE the fields come straight from IR; afterwards from the capture
   assign sel_op_s  = (state_q == ST_DECODE) ? ir_op_s  : op_q;
   assign sel_ra_s  = (state_q == ST_DECODE) ? ir_ra_s  : ra_q;
   assign sel_rb_s  = (state_q == ST_DECODE) ? ir_rb_s  : rb_q;
   assign sel_rc_s  = (state_q == ST_DECODE) ? ir_rc_s  : rc_q;
   assign sel_cls_s = (state_q == ST_DECODE) ? ir_cls_s : cls_q;

   assign illegal_trap_s = (state_q == ST_DECODE) && (ir_cls_s == ILLEGAL);
   assign next_instr_s   = run ? ST_FETCH0 : ST_IDLE;

   // Next-state, memory wait counter, fault accumulation, field capture
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      fault_d    = fault_q;
      op_d       = op_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      rc_d       = rc_q;
      cls_d      = cls_q;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH0;
            else     state_d = ST_IDLE;
         end
         ST_FETCH0: begin
            wait_cnt_d = 4'd0;
            state_d    = ST_FETCH1;
         end
         ST_FETCH1: begin
            if (mem_ready) begin
               state_d = ST_FETCH2;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_HALT;
               fault_d = fault_q | 2'b10;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         ST_FETCH2: state_d = ST_DECODE;
         ST_DECODE: begin
            op_d  = ir_op_s;
            ra_d  = ir_ra_s;
            rb_d  = ir_rb_s;
            rc_d  = ir_rc_s;
            cls_d = ir_cls_s;
            case (ir_cls_s)
               BINARY, MULDIV: state_d = ST_T3;
               UNARY:          state_d = ST_T4;
               default: begin
                  // Trap: flag it and skip straight to the next fetch
                  state_d = ST_FETCH0;
                  fault_d = fault_q | 2'b01;
               end
            endcase
         end
         ST_T3: state_d = ST_T4;
         ST_T4: state_d = ST_T5;
         ST_T5: begin
            if (cls_q == MULDIV) state_d = ST_T6;
            else                 state_d = next_instr_s;
         end
         ST_T6:   state_d = next_instr_s;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the state being entered, so outputs are registered
   always_comb begin
      stb_d  = '0;
      rin_d  = '0;
      rout_d = '0;
      alu_d  = '0;
      done_d = illegal_trap_s;
      busy_d = (state_d != ST_IDLE);
      case (state_d)
         ST_FETCH0: begin
            stb_d.pcout = 1'b1;
            stb_d.marin = 1'b1;
            stb_d.incpc = 1'b1;
            stb_d.zin   = 1'b1;
         end
         ST_FETCH1: begin
            stb_d.zlowout = 1'b1;
            stb_d.pcin    = 1'b1;
            stb_d.read    = 1'b1;
            stb_d.mdrin   = 1'b1;
         end
         ST_FETCH2: begin
            stb_d.mdrout = 1'b1;
            stb_d.irin   = 1'b1;
         end
         ST_T3: begin
            rout_d    = reg_onehot(sel_rb_s);
            stb_d.yin = 1'b1;
         end
         ST_T4: begin
            // Unary ops take their single operand from Rb
            if (sel_cls_s == UNARY) rout_d = reg_onehot(sel_rb_s);
            else                    rout_d = reg_onehot(sel_rc_s);
            stb_d.zin = 1'b1;
            alu_d     = sel_op_s;
         end
         ST_T5: begin
            stb_d.zlowout = 1'b1;
            if (sel_cls_s == MULDIV) begin
               stb_d.loin = 1'b1;
            end else begin
               rin_d  = reg_onehot(sel_ra_s);
               done_d = 1'b1;
            end
         end
         ST_T6: begin
            stb_d.zhighout = 1'b1;
            stb_d.hiin     = 1'b1;
            done_d         = 1'b1;
         end
         default: begin
            stb_d = '0;
         end
      endcase
   end

   // State and registered outputs; clear drops everything immediately
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
         fault_q    <= 2'b00;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         stb_q      <= '0;
         rin_q      <= '0;
         rout_q     <= '0;
         alu_q      <= '0;
         op_q       <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         rc_q       <= '0;
         cls_q      <= ILLEGAL;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         stb_q      <= stb_d;
         rin_q      <= rin_d;
         rout_q     <= rout_d;
         alu_q      <= alu_d;
         op_q       <= op_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         rc_q       <= rc_d;
         cls_q      <= cls_d;
      end
   end

   assign Rin      = rin_q;
   assign Rout     = rout_q;
   assign PCout    = stb_q.pcout;
   assign PCin     = stb_q.pcin;
   assign MARin    = stb_q.marin;
   assign MDRin    = stb_q.mdrin;
   assign MDRout   = stb_q.mdrout;
   assign IRin     = stb_q.irin;
   assign Yin      = stb_q.yin;
   assign Zin      = stb_q.zin;
   assign Zhighout = stb_q.zhighout;
   assign Zlowout  = stb_q.zlowout;
   assign HIin     = stb_q.hiin;
   assign LOin     = stb_q.loin;
   assign Read     = stb_q.read;
   assign IncPC    = stb_q.incpc;
   assign alu_op   = alu_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ctrl_sequencer
// Self-checking bench for ctrl_sequencer: a per-cycle vector table for the
// AND / NEG / MUL sequences, then hand-written memory-wait, illegal-opcode,
// clear-in-T4 and memory-timeout sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ctrl_sequencer;
   import cpu_pkg::*;

   logic                Clock = 1'b0;
   logic                clear, run, mem_ready;
   logic [31:0]         IR;
   logic [NUM_REGS-1:0] Rin, Rout;
   logic PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin;
   logic Zhighout, Zlowout, HIin, LOin, Read, IncPC;
   logic [OPCODE_W-1:0] alu_op;
   logic                busy, done;
   logic [1:0]          fault;

   int n_vec = 0;
   int n_err = 0;

   // Strobe bits in the order {PCout,PCin,MARin,MDRin,MDRout,IRin,Yin,Zin,
   // Zhighout,Zlowout,HIin,LOin,Read,IncPC}
   localparam logic [13:0] S_PCOUT = 14'h2000, S_PCIN  = 14'h1000, S_MARIN = 14'h0800;
   localparam logic [13:0] S_MDRIN = 14'h0400, S_MDROUT= 14'h0200, S_IRIN  = 14'h0100;
   localparam logic [13:0] S_YIN   = 14'h0080, S_ZIN   = 14'h0040, S_ZHI   = 14'h0020;
   localparam logic [13:0] S_ZLO   = 14'h0010, S_HIIN  = 14'h0008, S_LOIN  = 14'h0004;
   localparam logic [13:0] S_READ  = 14'h0002, S_INCPC = 14'h0001, S_NONE  = 14'h0000;
   localparam logic [13:0] F0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
   localparam logic [13:0] F1 = S_ZLO | S_PCIN | S_READ | S_MDRIN;
   localparam logic [13:0] F2 = S_MDROUT | S_IRIN;

   localparam logic [31:0] IR_AND = 32'h28918000;  // Ra=1 Rb=2 Rc=3
   localparam logic [31:0] IR_NEG = 32'h88880000;  // Ra=1 Rb=1
   localparam logic [31:0] IR_MUL = 32'h7A180000;  // Ra=4 Rb=3 Rc=0
   localparam logic [31:0] IR_ADD = 32'h192B8000;  // Ra=2 Rb=5 Rc=7
   localparam logic [31:0] IR_OR  = 32'h30000000;  // Ra=Rb=Rc=0
   localparam logic [31:0] IR_BAD = 32'hF8000000;  // opcode 11111

   typedef struct {
      logic        run;
      logic        mr;
      logic [31:0] ir;
      logic [13:0] stb;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  alu;
      logic        e_done;
      logic        e_busy;
      logic [1:0]  e_fault;
   } vec_t;

   vec_t tbl [0:21];

   ctrl_sequencer dut (
      .Clock(Clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
      .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
      .Read(Read), .IncPC(IncPC), .alu_op(alu_op), .busy(busy), .done(done),
      .fault(fault)
   );

   ctrl_sequencer_chk u_chk (
      .clk(Clock), .rst(clear), .rin(Rin), .rout(Rout), .pcout(PCout),
      .mdrout(MDRout), .zhighout(Zhighout), .zlowout(Zlowout)
   );

   always #5 Clock = ~Clock;

   function automatic logic [55:0] pack(input logic [13:0] s, input logic [15:0] ri,
                                        input logic [15:0] ro, input logic [4:0] a,
                                        input logic d, input logic b, input logic [1:0] f);
      pack = {s, ri, ro, a, d, b, f};
   endfunction

   task automatic expect_out(input string name, input logic [13:0] s, input logic [15:0] ri,
                             input logic [15:0] ro, input logic [4:0] a, input logic d,
                             input logic b, input logic [1:0] f);
      logic [55:0] got;
      logic [55:0] exp;
      got = pack({PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin,
                  Zhighout, Zlowout, HIin, LOin, Read, IncPC},
                 Rin, Rout, alu_op, done, busy, fault);
      exp = pack(s, ri, ro, a, d, b, f);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got stb=%h rin=%h rout=%h alu=%b done=%b busy=%b fault=%b, expected stb=%h rin=%h rout=%h alu=%b done=%b busy=%b fault=%b",
                  name, got[55:42], got[41:26], got[25:10], got[9:5], got[4], got[3], got[2:0],
                  s, ri, ro, a, d, b, f);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      // Per-cycle vectors: {run, mem_ready, IR, strobes, Rin, Rout, alu_op, done, busy, fault}
      tbl[0]  = '{1'b1, 1'b1, IR_AND, F0,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[1]  = '{1'b1, 1'b1, IR_AND, F1,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[2]  = '{1'b1, 1'b1, IR_AND, F2,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[3]  = '{1'b1, 1'b1, IR_AND, S_NONE, 16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[4]  = '{1'b1, 1'b1, IR_AND, S_YIN,  16'h0000, 16'h0004, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[5]  = '{1'b1, 1'b1, IR_AND, S_ZIN,  16'h0000, 16'h0008, 5'b00101, 1'b0, 1'b1, 2'b00};
      tbl[6]  = '{1'b1, 1'b1, IR_AND, S_ZLO,  16'h0002, 16'h0000, 5'b00000, 1'b1, 1'b1, 2'b00};
      // NEG with run dropped mid-instruction: it still completes
      tbl[7]  = '{1'b1, 1'b1, IR_NEG, F0,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[8]  = '{1'b0, 1'b1, IR_NEG, F1,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[9]  = '{1'b0, 1'b1, IR_NEG, F2,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[10] = '{1'b0, 1'b1, IR_NEG, S_NONE, 16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[11] = '{1'b0, 1'b1, IR_NEG, S_ZIN,  16'h0000, 16'h0002, 5'b10001, 1'b0, 1'b1, 2'b00};
      tbl[12] = '{1'b1, 1'b1, IR_NEG, S_ZLO,  16'h0002, 16'h0000, 5'b00000, 1'b1, 1'b1, 2'b00};
      // MUL: LO/HI writeback, no Rin
      tbl[13] = '{1'b1, 1'b1, IR_MUL, F0,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[14] = '{1'b1, 1'b1, IR_MUL, F1,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[15] = '{1'b1, 1'b1, IR_MUL, F2,     16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[16] = '{1'b1, 1'b1, IR_MUL, S_NONE, 16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[17] = '{1'b1, 1'b1, IR_MUL, S_YIN,  16'h0000, 16'h0008, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[18] = '{1'b1, 1'b1, IR_MUL, S_ZIN,  16'h0000, 16'h0001, 5'b01111, 1'b0, 1'b1, 2'b00};
      tbl[19] = '{1'b1, 1'b1, IR_MUL, S_ZLO | S_LOIN, 16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b1, 2'b00};
      tbl[20] = '{1'b0, 1'b1, IR_MUL, S_ZHI | S_HIIN, 16'h0000, 16'h0000, 5'b00000, 1'b1, 1'b1, 2'b00};
      tbl[21] = '{1'b0, 1'b1, IR_MUL, S_NONE, 16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b0, 2'b00};

      clear     = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b1;
      IR        = 32'h0;
      #12;
      expect_out("reset", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 2'b00);
      @(negedge Clock);
      clear = 1'b0;

      for (int i = 0; i < 22; i++) begin
         run       = tbl[i].run;
         mem_ready = tbl[i].mr;
         IR        = tbl[i].ir;
         step();
         expect_out($sformatf("row%0d", i), tbl[i].stb, tbl[i].rin, tbl[i].rout,
                    tbl[i].alu, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_fault);
      end

      // Memory wait: mem_ready low for 3 FETCH1 cycles holds FETCH1 for 4
      run = 1'b1; mem_ready = 1'b0; IR = IR_ADD;
      step(); expect_out("wait_f0", F0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      step(); expect_out("wait_f1_0", F1, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      for (int k = 1; k <= 3; k++) begin
         step(); expect_out($sformatf("wait_f1_%0d", k), F1, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      end
      mem_ready = 1'b1;
      step(); expect_out("wait_f2", F2, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      step(); expect_out("add_dec", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      step(); expect_out("add_t3", S_YIN, 16'h0, 16'h0020, 5'b0, 1'b0, 1'b1, 2'b00);
      step(); expect_out("add_t4", S_ZIN, 16'h0, 16'h0080, 5'b00011, 1'b0, 1'b1, 2'b00);
      run = 1'b0;
      step(); expect_out("add_t5", S_ZLO, 16'h0004, 16'h0, 5'b0, 1'b1, 1'b1, 2'b00);
      step(); expect_out("add_idle", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 2'b00);

      // Illegal opcode: trap, done, straight back to FETCH0
      run = 1'b1; IR = IR_BAD;
      step(); step(); step();
      step(); expect_out("ill_dec", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      step(); expect_out("ill_f0", F0, 16'h0, 16'h0, 5'b0, 1'b1, 1'b1, 2'b01);
      IR = IR_OR;
      step(); expect_out("or_f1", F1, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b01);
      step(); step();
      step(); expect_out("or_t3", S_YIN, 16'h0, 16'h0001, 5'b0, 1'b0, 1'b1, 2'b01);
      step(); expect_out("or_t4", S_ZIN, 16'h0, 16'h0001, 5'b00110, 1'b0, 1'b1, 2'b01);

      // clear inside T4: outputs drop before the next clock edge
      #2 clear = 1'b1;
      #1 expect_out("clear_t4", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 2'b00);
      step(); expect_out("clear_hold", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 2'b00);
      @(negedge Clock);
      clear = 1'b0;

      // Memory timeout: 15 low FETCH1 cycles -> HALT with fault[1]
      run = 1'b1; mem_ready = 1'b0; IR = IR_ADD;
      step(); expect_out("to_f0", F0, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      step(); expect_out("to_f1_0", F1, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      for (int k = 1; k <= 14; k++) begin
         step(); expect_out($sformatf("to_f1_%0d", k), F1, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b00);
      end
      step(); expect_out("to_halt", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b10);
      mem_ready = 1'b1;
      step(); step();
      expect_out("halt_stays", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b1, 2'b10);
      clear = 1'b1;
      #1 expect_out("halt_clear", S_NONE, 16'h0, 16'h0, 5'b0, 1'b0, 1'b0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
